// File: rtl/ahb2apb_pkg.sv
// Shared types, response codes and the write-strobe helper for the AHB-Lite to APB4 bridge.
package ahb2apb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte  = 3'd0,
    SizeHalf  = 3'd1,
    SizeWord  = 3'd2,
    SizeDword = 3'd3,
    Size4Word = 3'd4,
    Size8Word = 3'd5,
    Size512   = 3'd6,
    Size1024  = 3'd7
  } hsize_e;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWdata  = 3'd1,
    StSetup  = 3'd2,
    StAccess = 3'd3,
    StErr1   = 3'd4,
    StErr2   = 3'd5
  } state_e;

  localparam logic OKAY  = RespOkay;
  localparam logic ERROR = RespError;

  // Byte lanes for a legal (<= word) transfer; halfwords are forced onto an even lane pair.
  function automatic logic [3:0] calc_pstrb(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (hsize)
      3'd0:    strb = 4'b0001 << addr_lo;
      3'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'hF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one AHB beat at a time, one APB SETUP/ACCESS per beat,
// with all outputs registered from a single state machine.
module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter int unsigned AHB_AW = 32,
  parameter int unsigned AHB_DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [AHB_AW-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [AHB_DW-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [AHB_DW-1:0] hrdata,
  output logic [AHB_AW-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AHB_DW-1:0] pwdata,
  output logic [3:0]        pstrb,
  input  logic [AHB_DW-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (AHB_DW != 32) begin : g_dw_check
    $error("ahb2apb_bridge: AHB_DW must be 32");
  end

  state_e state_q;
  logic   req;

  // Bursts run as independent beats, so SEQ behaves like NONSEQ and hburst is not needed.
  assign req = hsel & hready & htrans[1];

  logic unused_inputs;
  assign unused_inputs = ^{hburst, htrans[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= 4'h0;
      hreadyout <= 1'b1;
      hresp     <= OKAY;
      hrdata    <= '0;
    end else begin
      case (state_q)
        StIdle, StErr2: begin
          state_q   <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= OKAY;
          psel      <= 1'b0;
          penable   <= 1'b0;
          if (req) begin
            hreadyout <= 1'b0;
            if (hsize > SizeWord) begin
              // Oversized transfers never reach APB.
              state_q <= StErr1;
              hresp   <= ERROR;
            end else begin
              paddr  <= haddr;
              pwrite <= hwrite;
              pstrb  <= hwrite ? calc_pstrb(hsize, haddr[1:0]) : 4'h0;
              if (hwrite) begin
                state_q <= StWdata;
              end else begin
                state_q <= StSetup;
                psel    <= 1'b1;
              end
            end
          end
        end

        StWdata: begin
          // hwdata is only valid in the AHB data phase, one cycle after the address.
          pwdata  <= hwdata;
          psel    <= 1'b1;
          penable <= 1'b0;
          state_q <= StSetup;
        end

        StSetup: begin
          penable <= 1'b1;
          state_q <= StAccess;
        end

        StAccess: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              state_q <= StErr1;
              hresp   <= ERROR;
            end else begin
              state_q   <= StIdle;
              hreadyout <= 1'b1;
              if (!pwrite) begin
                hrdata <= prdata;
              end
            end
          end
        end

        StErr1: begin
          state_q   <= StErr2;
          hreadyout <= 1'b1;
          hresp     <= ERROR;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end

        default: begin
          state_q   <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= OKAY;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule
